// File: rtl/hazard_pkg.sv
// Shared types and codes for the pipeline hazard scoreboard.
package hazard_pkg;

    // Internal tnew storage width; the top-level TW must not exceed it.
    localparam int TNEW_W = 4;

    localparam logic [1:0] TUSE_NONE = 2'b11;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;

    localparam logic [1:0] FWD_RF = 2'd0;

    typedef struct packed {
        logic              v;
        logic [4:0]        dst;
        logic [TNEW_W-1:0] tnew;
        logic              epc_w;
        logic              md;
    } sb_entry_t;

endpackage

// File: rtl/sb_entry_pipe.sv
// Shift register of in-flight instruction entries; tnew counts down as an
// entry moves toward WB, and a flush turns every next-state entry into a bubble.
module sb_entry_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  sb_entry_t             in_entry,
    output sb_entry_t [DEPTH-1:0] entries
);

    function automatic logic [TNEW_W-1:0] dec_sat(input logic [TNEW_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_W'(1);
    endfunction

    // Only the valid bits are reset; payload fields are don't-care while v=0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries[k].v <= 1'b0;
            end
        end else begin
            entries[0]   <= in_entry;
            entries[0].v <= in_entry.v && !flush;
            for (int k = 1; k < DEPTH; k++) begin
                entries[k]      <= entries[k-1];
                entries[k].tnew <= dec_sat(entries[k-1].tnew);
                entries[k].v    <= entries[k-1].v && !flush;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall/forward controller driven by a scoreboard of in-flight
// destination writes, an MDU busy countdown and pending EPC writes.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [TW-1:0] id_tuse_rs,
    input  logic [TW-1:0] id_tuse_rt,
    input  logic [4:0]    id_dst,
    input  logic [TW-1:0] id_tnew,
    input  logic [1:0]    id_md_op,
    input  logic          id_md_acc,
    input  logic          id_eret,
    input  logic          id_epc_w,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_rs_sel,
    output logic [1:0]    fwd_rt_sel,
    output logic          md_busy
);

    sb_entry_t [DEPTH-1:0] ents;
    sb_entry_t             in_ent;
    logic [DEPTH-1:0]      hit_rs;
    logic [DEPTH-1:0]      hit_rt;
    logic                  data_stall;
    logic                  epc_pend;
    logic                  md_stall;
    logic                  load;
    logic                  md_enter;
    logic [CW-1:0]         md_cnt;

    always_comb begin
        hit_rs     = '0;
        hit_rt     = '0;
        data_stall = 1'b0;
        epc_pend   = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            hit_rs[k] = ents[k].v && (ents[k].dst != 5'd0) && (ents[k].dst == id_rs);
            hit_rt[k] = ents[k].v && (ents[k].dst != 5'd0) && (ents[k].dst == id_rt);
            if (hit_rs[k] && (TNEW_W'(id_tuse_rs) < ents[k].tnew)) data_stall = 1'b1;
            if (hit_rt[k] && (TNEW_W'(id_tuse_rt) < ents[k].tnew)) data_stall = 1'b1;
            if (ents[k].v && ents[k].epc_w) epc_pend = 1'b1;
        end
    end

    assign md_busy  = (md_cnt != '0);
    assign md_stall = (id_md_acc || (id_md_op != MD_NONE)) &&
                      (md_busy || (ents[0].v && ents[0].md));
    assign stall    = id_valid && !flush &&
                      (data_stall || md_stall || (id_eret && epc_pend));

    // Scan oldest to youngest so the youngest ready producer wins.
    always_comb begin
        fwd_rs_sel = FWD_RF;
        fwd_rt_sel = FWD_RF;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit_rs[k] && (ents[k].tnew == '0)) fwd_rs_sel = 2'(k + 1);
            if (hit_rt[k] && (ents[k].tnew == '0)) fwd_rt_sel = 2'(k + 1);
        end
    end

    assign load     = id_valid && !stall && !flush;
    assign md_enter = load && (id_md_op != MD_NONE);

    always_comb begin
        in_ent       = '0;
        in_ent.v     = load;
        in_ent.dst   = id_dst;
        in_ent.tnew  = TNEW_W'(id_tnew);
        in_ent.epc_w = id_epc_w;
        in_ent.md    = (id_md_op != MD_NONE);
    end

    sb_entry_pipe #(
        .DEPTH(DEPTH)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .in_entry(in_ent),
        .entries (ents)
    );

    // A flushed MDU op in EX never started, so its countdown is cancelled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (flush && ents[0].v && ents[0].md) begin
            md_cnt <= '0;
        end else if (md_enter) begin
            md_cnt <= (id_md_op == MD_DIV) ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a queue-based expectation monitor.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dst;
    logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew, id_md_op;
    logic       id_md_acc, id_eret, id_epc_w, flush;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic       stall;
        logic [1:0] rs;
        logic [1:0] rt;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_tuse_rs(id_tuse_rs),
        .id_tuse_rt(id_tuse_rt),
        .id_dst    (id_dst),
        .id_tnew   (id_tnew),
        .id_md_op  (id_md_op),
        .id_md_acc (id_md_acc),
        .id_eret   (id_eret),
        .id_epc_w  (id_epc_w),
        .flush     (flush),
        .stall     (stall),
        .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel),
        .md_busy   (md_busy)
    );

    // Monitor: outputs are combinational and always present; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if ({stall, fwd_rs_sel, fwd_rt_sel, md_busy} !== {e.stall, e.rs, e.rt, e.busy}) begin
                failures++;
                $display("FAIL %s: got stall=%0d rs_sel=%0d rt_sel=%0d busy=%0d, want stall=%0d rs_sel=%0d rt_sel=%0d busy=%0d",
                         e.name, stall, fwd_rs_sel, fwd_rt_sel, md_busy,
                         e.stall, e.rs, e.rt, e.busy);
            end
        end
    end

    task automatic idle();
        id_valid   = 1'b0;
        id_rs      = 5'd0;
        id_rt      = 5'd0;
        id_tuse_rs = 2'b11;
        id_tuse_rt = 2'b11;
        id_dst     = 5'd0;
        id_tnew    = 2'd0;
        id_md_op   = 2'b00;
        id_md_acc  = 1'b0;
        id_eret    = 1'b0;
        id_epc_w   = 1'b0;
    endtask

    task automatic ins(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tur, input logic [1:0] tut,
                       input logic [4:0] dst, input logic [1:0] tn,
                       input logic [1:0] mdop, input logic acc,
                       input logic er, input logic epw);
        id_valid   = 1'b1;
        id_rs      = rs;
        id_rt      = rt;
        id_tuse_rs = tur;
        id_tuse_rt = tut;
        id_dst     = dst;
        id_tnew    = tn;
        id_md_op   = mdop;
        id_md_acc  = acc;
        id_eret    = er;
        id_epc_w   = epw;
    endtask

    // Queue the expected outputs for the current cycle, then advance one clock.
    task automatic chk(input logic s, input logic [1:0] r, input logic [1:0] t,
                       input logic b, input string nm);
        exp_t e;
        e.name  = nm;
        e.stall = s;
        e.rs    = r;
        e.rt    = t;
        e.busy  = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        flush = 1'b0;
        idle();
        @(posedge clk);
        #1;
        chk(0, 0, 0, 0, "reset_state");
        reset = 1'b1;

        ins(0, 0, 3, 3, 1, 2, 0, 0, 0, 0);  chk(0, 0, 0, 0, "lw_issue");
        ins(1, 3, 1, 1, 2, 1, 0, 0, 0, 0);  chk(1, 0, 0, 0, "lw_use_stall");
        chk(0, 0, 0, 0, "lw_use_release");
        ins(1, 2, 1, 1, 6, 1, 0, 0, 0, 0);  chk(0, 3, 0, 0, "fwd_from_wb");
        ins(2, 6, 1, 1, 4, 1, 0, 0, 0, 0);  chk(0, 2, 0, 0, "fwd_from_ma");
        ins(4, 0, 0, 0, 0, 0, 0, 0, 0, 0);  chk(1, 0, 0, 0, "beq_stall");
        chk(0, 2, 0, 0, "beq_fwd");
        ins(0, 0, 0, 0, 5, 1, 0, 0, 0, 0);  chk(0, 0, 0, 0, "r0_source");
        ins(7, 5, 1, 2, 0, 0, 0, 0, 0, 0);  chk(0, 0, 0, 0, "sw_late_use");
        ins(0, 5, 3, 3, 0, 0, 0, 0, 0, 0);  chk(0, 0, 2, 0, "rt_fwd_ma");

        ins(0, 0, 3, 3, 0, 0, 2'b01, 0, 0, 0);  chk(0, 0, 0, 0, "mult_issue");
        ins(0, 0, 3, 3, 8, 1, 2'b00, 1, 0, 0);
        for (int i = 0; i < 5; i++) chk(1, 0, 0, 1, "mflo_wait");
        chk(0, 0, 0, 0, "mflo_release");

        ins(0, 0, 3, 3, 0, 0, 0, 0, 0, 1);  chk(0, 0, 0, 0, "mtc0_issue");
        ins(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);  chk(0, 0, 0, 0, "nop_issue");
        ins(0, 0, 3, 3, 0, 0, 0, 0, 1, 0);  chk(1, 0, 0, 0, "eret_ma");
        chk(1, 0, 0, 0, "eret_wb");
        chk(0, 0, 0, 0, "eret_release");

        ins(0, 0, 3, 3, 0, 0, 2'b10, 0, 0, 0);  chk(0, 0, 0, 0, "div_issue");
        ins(0, 0, 3, 3, 8, 1, 2'b00, 1, 0, 0);
        flush = 1'b1;                       chk(0, 0, 0, 1, "flush_blocks_stall");
        flush = 1'b0;
        idle();                             chk(0, 0, 0, 0, "div_cancelled");

        ins(0, 0, 3, 3, 0, 0, 2'b10, 0, 0, 0);  chk(0, 0, 0, 0, "div2_issue");
        ins(0, 0, 3, 3, 8, 1, 2'b00, 1, 0, 0);
        for (int i = 0; i < 3; i++) chk(1, 0, 0, 1, "div2_wait");
        reset = 1'b0;                       chk(1, 0, 0, 1, "cnt7_reset_edge");
        reset = 1'b1;                       chk(0, 0, 0, 0, "after_reset");

        ins(0, 0, 3, 3, 0, 0, 2'b01, 0, 0, 0);  chk(0, 0, 0, 0, "mult2_issue");
        ins(0, 0, 3, 3, 0, 0, 0, 0, 0, 0);  chk(0, 0, 0, 1, "mult2_busy");
        idle();
        flush = 1'b1;                       chk(0, 0, 0, 1, "flush_no_md");
        flush = 1'b0;                       chk(0, 0, 0, 1, "flush_keeps_cnt");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
